am_block_inserter_r: RTL and testbench
======================================

# am_block_inserter_r

Inserts alignment-marker (AM) blocks into the 257-bit block stream, immediately upstream of `flow_distributor_r`. Each frame of `BLOCKS_REPETITION` output blocks starts with `MAX_BLOCKS_AM` AM blocks sliced from a pre-mapped AM vector, followed by pass-through data blocks. While it emits AM blocks, the block stalls its upstream source with `o_ready`. Output is one block per cycle with a valid strobe, matching the distributor's `i_valid`/`input_blocks` interface, which has no backpressure.

## Interface
- `BITS_BLOCK`, 257: bits per block.
- `MAX_BLOCKS_AM`, 40: AM blocks per frame. Must be even and ≥1.
- `BLOCKS_REPETITION`, 8192: total blocks per frame, AM included. Must be even and > `MAX_BLOCKS_AM`.
- `AM_MAPPED_WIDTH`, 10280: width of the AM vector. Equals `MAX_BLOCKS_AM*BITS_BLOCK`.
- `clk`, in, 1: single clock. All logic is on the rising edge.
- `rst`, in, 1: reset, synchronous, active-high.
- `i_valid`, in, 1: upstream data block valid.
- `i_data`, in, `BITS_BLOCK`: upstream data block.
- `o_ready`, out, 1: the block accepts `i_data` this cycle.
- `i_am_mapped`, in, `AM_MAPPED_WIDTH`: AM content. Block k is bits `[k*BITS_BLOCK +: BITS_BLOCK]`.
- `o_valid`, out, 1: `o_block` valid. Connects to distributor `i_valid`.
- `o_block`, out, `BITS_BLOCK`: output block. Connects to distributor `input_blocks`.
- `o_is_am`, out, 1: the current `o_block` is an AM block.

## Operation
- There are two states: `AM` and `DATA`.
- Counters:
  - `am_idx` is `$clog2(MAX_BLOCKS_AM)` bits wide and counts 0..`MAX_BLOCKS_AM-1`.
  - `data_cnt` is `$clog2(BLOCKS_REPETITION)` bits wide and counts 0..`BLOCKS_REPETITION-MAX_BLOCKS_AM-1`.
- `am_shadow` is an `AM_MAPPED_WIDTH` register. It loads `i_am_mapped` every cycle `rst` is high, and on the cycle the FSM goes from `DATA` to `AM`. It holds its value otherwise, so AM content is stable for a whole group.
- In `AM`:
  - `o_ready`=0.
  - Each cycle: `o_block` ← slice `am_idx` of `am_shadow`, `o_valid` ← 1, `o_is_am` ← 1, then `am_idx`++.
  - After slice `MAX_BLOCKS_AM-1` is emitted: `am_idx` ← 0, state ← `DATA`.
  - AM blocks are emitted back to back and ignore `i_valid`.
- In `DATA`:
  - `o_ready`=1, decoded from the state register (no combinational path from inputs).
  - A transfer occurs when `i_valid && o_ready`. On a transfer: `o_block` ← `i_data`, `o_valid` ← 1, `o_is_am` ← 0, `data_cnt`++.
  - With no transfer: `o_valid` ← 0, and `o_block` holds its value.
  - On the transfer where `data_cnt` = last: `data_cnt` ← 0, state ← `AM`, and `am_shadow` reloads.
  - Gaps in `i_valid` stretch the frame in time but not in block count.
- Frame composition: exactly `MAX_BLOCKS_AM` AM blocks plus `BLOCKS_REPETITION-MAX_BLOCKS_AM` data blocks, i.e. 40 + 8152 at the defaults.
- Both counts are even, so every AM group starts on a `flow_0` slot of the distributor.
- `i_data` presented while `o_ready`=0 is not consumed. Upstream must hold it.

## Timing
- Reset values: state=`AM`, `am_idx`=0, `data_cnt`=0, `o_valid`=0, `o_block`=0, `o_is_am`=0, `o_ready`=0.
- First cycle after `rst` falls: the FSM is in `AM`. AM block k is visible after edge k+1 following reset release.
- Data latency: a block accepted at edge N appears on `o_block` with `o_valid`=1 after edge N. One register stage.
- `o_ready` rises in the cycle after the last AM block is registered. It falls in the cycle after the last data transfer of a frame.
- When the last data transfer coincides with `i_am_mapped` changing, the new value is captured for the next group.
- `rst` asserted mid-frame: all state returns to reset values at that edge, and any partially emitted AM group is abandoned. After release, a fresh frame starts with AM block 0.
- `i_valid` held high continuously gives 100% output utilisation: an AM group follows the last data block with zero bubble.

## Structure
- Shared package `aui_pkg`:
  - `BITS_BLOCK`, `MAX_BLOCKS_AM`, `BLOCKS_REPETITION`, and derived `DATA_BLOCKS_PER_FRAME`.
  - `typedef logic [BITS_BLOCK-1:0] block_t`.
  - `typedef enum logic {ST_AM, ST_DATA} am_ins_state_t`.
  - These are reused by `flow_distributor_r` and the later FEC stages.
- No sub-module is required. AM slice selection is an indexed part-select on `am_shadow`.
- Parameter legality (even counts, width equality) is checked with elaboration-time assertions.

## Test plan
Bench parameters: `MAX_BLOCKS_AM`=4, `BLOCKS_REPETITION`=16, `AM_MAPPED_WIDTH`=1028. AM slice k is filled with 0xA0+k.
- Reset release, `i_valid`=1 constant with an incrementing `i_data` 0,1,2… → outputs are A0,A1,A2,A3 (`o_is_am`=1), then data 0..11, then A0..A3 again with no bubble; `o_ready` is low for exactly 4 of every 16 cycles.
- Random `i_valid` gaps → each frame still has exactly 12 data blocks and `o_valid` is high only on transfers; data order and values are unchanged.
- `i_am_mapped` changed mid-group → the current group keeps its old slices; the next group shows the new values.
- `rst` pulsed after 2 AM blocks or after 5 data blocks → outputs read 0 during reset, then the sequence restarts at A0 with `data_cnt` cleared.
- `i_valid`=1 while `o_ready`=0 → `i_data` is not consumed; the held word is output first once `o_ready` rises.
- Feed the output into `flow_distributor_r` → A0 and A2 land on `flow_0`, A1 and A3 on `flow_1`, in every frame.

Source files
------------

// File: rtl/aui_pkg.sv
// Shared block-stream types and default frame geometry for the AM inserter,
// flow distributor and downstream FEC stages.
// No logic: constants and typedefs only.
package aui_pkg;

    localparam int BITS_BLOCK            = 257;
    localparam int MAX_BLOCKS_AM         = 40;
    localparam int BLOCKS_REPETITION     = 8192;
    localparam int DATA_BLOCKS_PER_FRAME = BLOCKS_REPETITION - MAX_BLOCKS_AM;

    typedef logic [BITS_BLOCK-1:0] block_t;

    typedef enum logic {ST_AM, ST_DATA} am_ins_state_t;

endpackage

// File: rtl/am_block_inserter_r.sv
// Prepends MAX_BLOCKS_AM alignment-marker blocks to every frame of BLOCKS_REPETITION blocks.
// Latency: one register stage from accepted i_data or AM slice to o_block.
// Backpressure: o_ready low for the whole AM group; the output side has none.
module am_block_inserter_r
    import aui_pkg::*;
#(
    parameter int BITS_BLOCK        = aui_pkg::BITS_BLOCK,
    parameter int MAX_BLOCKS_AM     = aui_pkg::MAX_BLOCKS_AM,
    parameter int BLOCKS_REPETITION = aui_pkg::BLOCKS_REPETITION,
    parameter int AM_MAPPED_WIDTH   = aui_pkg::MAX_BLOCKS_AM * aui_pkg::BITS_BLOCK
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       i_valid,
    input  logic [BITS_BLOCK-1:0]      i_data,
    output logic                       o_ready,
    input  logic [AM_MAPPED_WIDTH-1:0] i_am_mapped,
    output logic                       o_valid,
    output logic [BITS_BLOCK-1:0]      o_block,
    output logic                       o_is_am
);

    localparam int AM_IDX_W    = $clog2(MAX_BLOCKS_AM);
    localparam int DATA_CNT_W  = $clog2(BLOCKS_REPETITION);
    localparam int DATA_BLOCKS = BLOCKS_REPETITION - MAX_BLOCKS_AM;

    localparam logic [AM_IDX_W-1:0]   AM_LAST   = AM_IDX_W'(MAX_BLOCKS_AM - 1);
    localparam logic [DATA_CNT_W-1:0] DATA_LAST = DATA_CNT_W'(DATA_BLOCKS - 1);

    // Even group sizes keep every AM group aligned to flow_0 of the distributor.
    if (MAX_BLOCKS_AM < 2 || (MAX_BLOCKS_AM % 2) != 0) begin : g_bad_am_count
        $error("MAX_BLOCKS_AM must be even and non-zero");
    end
    if ((BLOCKS_REPETITION % 2) != 0 || BLOCKS_REPETITION <= MAX_BLOCKS_AM) begin : g_bad_frame
        $error("BLOCKS_REPETITION must be even and larger than MAX_BLOCKS_AM");
    end
    if (AM_MAPPED_WIDTH != MAX_BLOCKS_AM * BITS_BLOCK) begin : g_bad_am_width
        $error("AM_MAPPED_WIDTH must equal MAX_BLOCKS_AM * BITS_BLOCK");
    end

    am_ins_state_t              state;
    am_ins_state_t              state_nxt;
    logic [AM_IDX_W-1:0]        am_idx;
    logic [DATA_CNT_W-1:0]      data_cnt;
    logic [AM_MAPPED_WIDTH-1:0] am_shadow;
    logic                       xfer;
    logic                       am_last;
    logic                       data_last;
    int                         am_off;

    assign o_ready   = (state == ST_DATA);
    assign xfer      = i_valid && o_ready;
    assign am_last   = (am_idx == AM_LAST);
    assign data_last = (data_cnt == DATA_LAST);
    assign am_off    = BITS_BLOCK * int'(am_idx);

    always_comb begin
        state_nxt = state;
        case (state)
            ST_AM:   if (am_last) state_nxt = ST_DATA;
            ST_DATA: if (xfer && data_last) state_nxt = ST_AM;
            default: state_nxt = ST_AM;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= ST_AM;
        end else begin
            state <= state_nxt;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            am_idx    <= '0;
            data_cnt  <= '0;
            o_valid   <= 1'b0;
            o_block   <= '0;
            o_is_am   <= 1'b0;
            am_shadow <= i_am_mapped;
        end else begin
            o_valid <= 1'b0;
            o_is_am <= 1'b0;
            if (state == ST_AM) begin
                o_block <= am_shadow[am_off +: BITS_BLOCK];
                o_valid <= 1'b1;
                o_is_am <= 1'b1;
                am_idx  <= am_last ? '0 : am_idx + 1'b1;
            end else if (xfer) begin
                o_block  <= i_data;
                o_valid  <= 1'b1;
                data_cnt <= data_last ? '0 : data_cnt + 1'b1;
                // Snapshot AM content so a whole group is emitted from one value.
                if (data_last) begin
                    am_shadow <= i_am_mapped;
                end
            end
        end
    end

endmodule

// File: tb/tb_am_block_inserter_r.sv
// Bench for am_block_inserter_r with a 4-AM / 16-block frame.
module tb_am_block_inserter_r;

    localparam int BB = 257;
    localparam int MA = 4;
    localparam int BR = 16;
    localparam int AW = MA * BB;
    localparam int ND = BR - MA;

    typedef logic [BB-1:0] blk_t;

    logic           clk = 1'b0;
    logic           rst;
    logic           i_valid;
    blk_t           i_data;
    logic           o_ready;
    logic [AW-1:0]  i_am_mapped;
    logic           o_valid;
    blk_t           o_block;
    logic           o_is_am;

    int tests = 0;
    int fails = 0;

    am_block_inserter_r #(
        .BITS_BLOCK       (BB),
        .MAX_BLOCKS_AM    (MA),
        .BLOCKS_REPETITION(BR),
        .AM_MAPPED_WIDTH  (AW)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .i_valid    (i_valid),
        .i_data     (i_data),
        .o_ready    (o_ready),
        .i_am_mapped(i_am_mapped),
        .o_valid    (o_valid),
        .o_block    (o_block),
        .o_is_am    (o_is_am)
    );

    always #5 clk = ~clk;

    function automatic blk_t am_word(input logic [7:0] b);
        return {1'b1, {32{b}}};
    endfunction

    function automatic blk_t dat_word(input int n);
        logic [31:0] v;
        v = n;
        return {1'b0, {8{v}}};
    endfunction

    function automatic logic [AW-1:0] am_vec(input logic [7:0] base);
        logic [AW-1:0] v;
        v = '0;
        for (int k = 0; k < MA; k++) v[k*BB +: BB] = am_word(base + 8'(k));
        return v;
    endfunction

    task automatic chk(input string name, input blk_t act, input blk_t exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic chk1(input string name, input logic act, input logic exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %b expected %b", name, act, exp);
        end
    endtask

    // Reference frame model
    logic       m_in_am;
    int         m_am_k;
    int         m_dcnt;
    logic [7:0] m_cur_base;
    logic [7:0] m_sh_base;
    int         m_next_n = 0;
    int         m_pos;

    task automatic set_am(input logic [7:0] base);
        m_cur_base  = base;
        i_am_mapped = am_vec(base);
    endtask

    task automatic do_reset();
        rst     = 1'b1;
        i_valid = 1'b1;
        i_data  = dat_word(m_next_n);
        repeat (2) begin
            @(posedge clk); #1;
            chk1("rst_vld", o_valid, 1'b0);
            chk1("rst_am", o_is_am, 1'b0);
            chk1("rst_rdy", o_ready, 1'b0);
            chk("rst_blk", o_block, '0);
        end
        rst       = 1'b0;
        m_in_am   = 1'b1;
        m_am_k    = 0;
        m_dcnt    = 0;
        m_sh_base = m_cur_base;
        m_pos     = 0;
    endtask

    task automatic cyc(input logic vld);
        logic acc;
        chk1("ready", o_ready, !m_in_am);
        i_valid = vld;
        i_data  = dat_word(m_next_n);
        acc     = vld && !m_in_am;
        @(posedge clk); #1;
        if (m_in_am) begin
            chk1("am_vld", o_valid, 1'b1);
            chk1("am_flag", o_is_am, 1'b1);
            chk("am_blk", o_block, am_word(m_sh_base + 8'(m_am_k)));
            if (m_am_k == 0 || m_am_k == 2) chk1("am_flow0", m_pos[0], 1'b0);
            m_am_k++;
            if (m_am_k == MA) begin
                m_in_am = 1'b0;
                m_am_k  = 0;
            end
        end else if (acc) begin
            chk1("dat_vld", o_valid, 1'b1);
            chk1("dat_flag", o_is_am, 1'b0);
            chk("dat_blk", o_block, dat_word(m_next_n));
            m_next_n++;
            m_dcnt++;
            if (m_dcnt == ND) begin
                m_dcnt    = 0;
                m_in_am   = 1'b1;
                m_sh_base = m_cur_base;
            end
        end else begin
            chk1("idle_vld", o_valid, 1'b0);
        end
        if (o_valid === 1'b1) m_pos++;
    endtask

    typedef struct {
        logic vld;
        blk_t dat;
        logic e_vld;
        blk_t e_blk;
        logic e_am;
        logic e_rdy;
    } vec_t;

    vec_t tbl[21];

    initial begin
        // Continuous-valid frame: data word 0 is presented during the AM group and held.
        for (int k = 0; k < 4; k++)
            tbl[k] = '{1'b1, dat_word(0), 1'b1, am_word(8'hA0 + 8'(k)), 1'b1, (k == 3)};
        for (int k = 4; k < 16; k++)
            tbl[k] = '{1'b1, dat_word(k == 4 ? 0 : k - 4), 1'b1, dat_word(k - 4), 1'b0, (k != 15)};
        for (int k = 16; k < 20; k++)
            tbl[k] = '{1'b1, dat_word(12), 1'b1, am_word(8'hA0 + 8'(k - 16)), 1'b1, (k == 19)};
        tbl[20] = '{1'b1, dat_word(12), 1'b1, dat_word(12), 1'b0, 1'b1};

        rst     = 1'b1;
        i_valid = 1'b0;
        i_data  = '0;
        set_am(8'hA0);
        do_reset();

        foreach (tbl[k]) begin
            i_valid = tbl[k].vld;
            i_data  = tbl[k].dat;
            @(posedge clk); #1;
            chk1($sformatf("t%0d_vld", k), o_valid, tbl[k].e_vld);
            chk($sformatf("t%0d_blk", k), o_block, tbl[k].e_blk);
            chk1($sformatf("t%0d_am", k), o_is_am, tbl[k].e_am);
            chk1($sformatf("t%0d_rdy", k), o_ready, tbl[k].e_rdy);
        end

        // Random valid gaps over several frames
        m_next_n = 100;
        do_reset();
        for (int c = 0; c < 150; c++) cyc($urandom_range(0, 2) != 0);

        // AM content changed mid-group, then again on the last data transfer
        do_reset();
        cyc(1'b1);
        cyc(1'b1);
        set_am(8'hB0);
        repeat (2 + ND + MA) cyc(1'b1);
        repeat (ND - 1) cyc(1'b1);
        set_am(8'hC0);
        cyc(1'b1);
        repeat (MA + 2) cyc(1'b1);

        // Reset after 2 AM blocks, then after 5 data blocks
        do_reset();
        cyc(1'b1);
        cyc(1'b1);
        do_reset();
        repeat (BR + MA) cyc(1'b1);
        repeat (5) cyc(1'b1);
        do_reset();
        repeat (BR + MA + 2) cyc(1'b1);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
